alu_selftest_ctrl: RTL and testbench
====================================

ALU_SELFTEST_CTRL -- requirements
Module: alu_selftest_ctrl

Interface
REQ-001 Parameter TEST_PERIOD, default 256, SHALL set the number of CPU-idle cycles between self-test sweeps (legal range 2..65535).
REQ-002 Parameter FAULT_LIMIT, default 2, SHALL set the number of failed sweeps that raises alu_fault (legal range 1..15).
REQ-003 Ports SHALL be, in order:
 - clk  in  1  single clock, rising edge.
 - reset  in  1  synchronous, active-high.
 - test_en  in  1  enables periodic self-test.
 - cpu_req  in  1  CPU is using the ALU this cycle.
 - cpu_a, cpu_b  in  32  CPU operands.
 - cpu_alucont  in  3  CPU ALU opcode.
 - alu_a, alu_b  out  32  operands to the shared voted ALU.
 - alu_alucont  out  3  opcode to the shared voted ALU.
 - alu_result  in  32  voted ALU result.
 - alu_zero  in  1  voted ALU zero flag.
 - test_busy  out  1  a sweep is in progress.
 - test_pass_cnt  out  8  passed sweeps, saturating.
 - fault_cnt  out  4  failed sweeps, saturating.
 - alu_fault  out  1  sticky fault indication.

Function
REQ-004 The ALU port mux SHALL be combinational: alu_a/alu_b/alu_alucont equal the cpu_* inputs unless state is RUN and cpu_req=0, in which case they equal test vector[idx].
REQ-005 The CPU SHALL always have priority; a test vector SHALL never be driven in a cycle with cpu_req=1.
REQ-006 FSM states SHALL be IDLE, WAIT, RUN and REPORT.
REQ-007 IDLE -> WAIT SHALL occur when test_en=1; the 16-bit idle counter SHALL clear on entry to WAIT.
REQ-008 In WAIT, the counter SHALL increment on each cycle with cpu_req=0 and hold otherwise; WAIT -> RUN SHALL occur on the edge at which the counter equals TEST_PERIOD-1 with cpu_req=0; idx SHALL clear to 0 and the sweep-fail flag SHALL clear.
REQ-009 In RUN with cpu_req=0, at the clock edge the block SHALL compare {alu_result, alu_zero} against the expected value for idx, set the sweep-fail flag on mismatch, and increment idx.
REQ-010 In RUN with cpu_req=1, idx SHALL hold: the sweep resumes without restarting.
REQ-011 After vector 4 completes, the FSM SHALL enter REPORT. REPORT SHALL last 1 cycle: on fail, fault_cnt increments (saturate 15); on pass, test_pass_cnt increments (saturate 255). REPORT SHALL then go to WAIT.
REQ-012 alu_fault SHALL set on the edge where fault_cnt becomes >= FAULT_LIMIT and SHALL remain 1 until reset.
REQ-013 test_en=0 in any state SHALL force IDLE on the next edge; a partial sweep SHALL be discarded with no counter update. Exception: in REPORT, the update SHALL complete and the FSM SHALL then go to IDLE.
REQ-014 test_busy SHALL be 1 exactly when state is RUN or REPORT.
REQ-015 Test vectors (a, b, alucont -> result, zero) SHALL be:
 - V0: F0F0F0F0, 0FF00FF0, 000 -> 00F000F0, 0.
 - V1: same operands, 001 -> FFF0FFF0, 0.
 - V2: 7FFFFFFF, 00000001, 010 -> 80000000, 0.
 - V3: 00000005, 00000005, 110 -> 00000000, 1.
 - V4: 00000003, 00000007, 111 -> 00000001, 0.

Reset
REQ-016 On reset, the block SHALL enter IDLE and clear the idle counter, idx, the sweep-fail flag, test_busy, test_pass_cnt, fault_cnt and alu_fault.
REQ-017 Reset asserted mid-sweep SHALL abort the sweep with no counter update; the alu_* outputs SHALL follow cpu_* from the cycle after reset.

Structure
REQ-018 State encoding, vector count (5) and the V0..V4 constants SHALL reside in the shared ALU package/include, reusable by the bench.
REQ-019 The vector table SHALL be a sub-module alu_test_rom: idx[2:0] in; a, b, alucont, exp_result, exp_zero out; purely combinational.
REQ-020 Comparison, counters and the FSM SHALL reside in alu_selftest_ctrl; the ALU itself SHALL stay external.

Verification
REQ-021 Bench SHALL cover: TEST_PERIOD=4, test_en=1, cpu_req=0, correct ALU model -> RUN entered after 4 idle cycles, test_busy high 6 cycles (5 RUN + 1 REPORT), test_pass_cnt=1, fault_cnt=0.
REQ-022 Bench SHALL cover: cpu_req=1 for 3 cycles while idx=2 -> alu_* equal cpu_* for those cycles, then V2..V4 issued, sweep passes, no restart.
REQ-023 Bench SHALL cover: ALU model forcing alu_result bit0 stuck-at-1, FAULT_LIMIT=2 -> fault_cnt=1 after sweep 1, fault_cnt=2 and alu_fault=1 after sweep 2; alu_fault stays 1 after the fault is removed.
REQ-024 Bench SHALL cover: test_en dropped at idx=3 -> IDLE next cycle, counters unchanged; re-enable -> full TEST_PERIOD wait before the next sweep.
REQ-025 Bench SHALL cover: reset asserted in RUN -> all outputs zero and alu_*=cpu_* next cycle; 300 passing sweeps -> test_pass_cnt saturates at 255.

Source files
------------

// File: rtl/alu_selftest_ctrl_pkg.sv
// Shared definitions for the ALU self-test controller: FSM states and the
// built-in test vector set, reusable by both RTL and bench.
package alu_selftest_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN,
    REPORT
  } state_e;

  localparam int unsigned NUM_VEC = 5;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alucont;
    logic [31:0] result;
    logic        zero;
  } test_vec_t;

  localparam test_vec_t V0 = '{a: 32'hF0F0F0F0, b: 32'h0FF00FF0, alucont: 3'b000,
                               result: 32'h00F000F0, zero: 1'b0};
  localparam test_vec_t V1 = '{a: 32'hF0F0F0F0, b: 32'h0FF00FF0, alucont: 3'b001,
                               result: 32'hFFF0FFF0, zero: 1'b0};
  localparam test_vec_t V2 = '{a: 32'h7FFFFFFF, b: 32'h00000001, alucont: 3'b010,
                               result: 32'h80000000, zero: 1'b0};
  localparam test_vec_t V3 = '{a: 32'h00000005, b: 32'h00000005, alucont: 3'b110,
                               result: 32'h00000000, zero: 1'b1};
  localparam test_vec_t V4 = '{a: 32'h00000003, b: 32'h00000007, alucont: 3'b111,
                               result: 32'h00000001, zero: 1'b0};

  function automatic test_vec_t get_test_vec(input logic [2:0] idx);
    test_vec_t v;
    case (idx)
      3'd0:    v = V0;
      3'd1:    v = V1;
      3'd2:    v = V2;
      3'd3:    v = V3;
      3'd4:    v = V4;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_test_rom.sv
// Combinational lookup of the self-test vector and its expected ALU response.
module alu_test_rom
  import alu_selftest_ctrl_pkg::*;
(
  input  logic [2:0]  idx,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  alucont,
  output logic [31:0] exp_result,
  output logic        exp_zero
);

  test_vec_t vec;

  assign vec        = get_test_vec(idx);
  assign a          = vec.a;
  assign b          = vec.b;
  assign alucont    = vec.alucont;
  assign exp_result = vec.result;
  assign exp_zero   = vec.zero;

endmodule

// File: rtl/alu_selftest_ctrl.sv
// Periodic ALU self-test: steals CPU-idle cycles on the shared voted ALU,
// checks its responses against a fixed vector set and tracks pass/fail sweeps.
module alu_selftest_ctrl
  import alu_selftest_ctrl_pkg::*;
#(
  parameter int unsigned TEST_PERIOD = 256,
  parameter int unsigned FAULT_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        test_en,
  input  logic        cpu_req,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_b,
  input  logic [2:0]  cpu_alucont,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_alucont,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        test_busy,
  output logic [7:0]  test_pass_cnt,
  output logic [3:0]  fault_cnt,
  output logic        alu_fault
);

  localparam logic [15:0] LAST_IDLE = 16'(TEST_PERIOD - 1);
  localparam logic [3:0]  FAULT_LIM = 4'(FAULT_LIMIT);
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_VEC - 1);

  state_e      state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        fail_q, fail_d;
  logic [7:0]  pass_cnt_q, pass_cnt_d;
  logic [3:0]  fault_cnt_q, fault_cnt_d;
  logic        fault_q, fault_d;

  logic [31:0] rom_a, rom_b, rom_result;
  logic [2:0]  rom_alucont;
  logic        rom_zero;
  logic        vec_sel, vec_ok;

  alu_test_rom u_rom (
    .idx        (idx_q),
    .a          (rom_a),
    .b          (rom_b),
    .alucont    (rom_alucont),
    .exp_result (rom_result),
    .exp_zero   (rom_zero)
  );

  // CPU always wins the ALU; a vector is only presented on idle RUN cycles
  assign vec_sel     = (state_q == RUN) && !cpu_req;
  assign alu_a       = vec_sel ? rom_a       : cpu_a;
  assign alu_b       = vec_sel ? rom_b       : cpu_b;
  assign alu_alucont = vec_sel ? rom_alucont : cpu_alucont;
  assign vec_ok      = ({alu_result, alu_zero} == {rom_result, rom_zero});

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    idx_d       = idx_q;
    fail_d      = fail_q;
    pass_cnt_d  = pass_cnt_q;
    fault_cnt_d = fault_cnt_q;
    case (state_q)
      IDLE: begin
        if (test_en) begin
          state_d    = WAIT;
          idle_cnt_d = '0;
        end
      end
      WAIT: begin
        if (!test_en) begin
          state_d = IDLE;
        end else if (!cpu_req) begin
          if (idle_cnt_q == LAST_IDLE) begin
            state_d = RUN;
            idx_d   = '0;
            fail_d  = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      RUN: begin
        if (!test_en) begin
          state_d = IDLE;
        end else if (!cpu_req) begin
          if (!vec_ok) fail_d = 1'b1;
          if (idx_q == LAST_IDX) state_d = REPORT;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      REPORT: begin
        // The tally always completes here, even if test_en has just dropped
        if (fail_q) begin
          if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 4'd1;
        end else if (pass_cnt_q != '1) begin
          pass_cnt_d = pass_cnt_q + 8'd1;
        end
        idle_cnt_d = '0;
        state_d    = test_en ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    fault_d = fault_q | (fault_cnt_d >= FAULT_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idle_cnt_q  <= '0;
      idx_q       <= '0;
      fail_q      <= 1'b0;
      pass_cnt_q  <= '0;
      fault_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      idx_q       <= idx_d;
      fail_q      <= fail_d;
      pass_cnt_q  <= pass_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign test_busy     = (state_q == RUN) || (state_q == REPORT);
  assign test_pass_cnt = pass_cnt_q;
  assign fault_cnt     = fault_cnt_q;
  assign alu_fault     = fault_q;

endmodule

// File: tb/tb_alu_selftest_ctrl.sv
// Self-checking bench for alu_selftest_ctrl with a behavioural voted-ALU model
// and a scoreboard of the test vectors expected on the ALU port.
module tb_alu_selftest_ctrl;
  import alu_selftest_ctrl_pkg::*;

  logic        clk, reset, test_en, cpu_req;
  logic [31:0] cpu_a, cpu_b, alu_a, alu_b, alu_result;
  logic [2:0]  cpu_alucont, alu_alucont;
  logic        alu_zero, test_busy, alu_fault;
  logic [7:0]  test_pass_cnt;
  logic [3:0]  fault_cnt;
  logic        stuck;

  int checks = 0;
  int errors = 0;

  alu_selftest_ctrl #(.TEST_PERIOD(4), .FAULT_LIMIT(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .test_en       (test_en),
    .cpu_req       (cpu_req),
    .cpu_a         (cpu_a),
    .cpu_b         (cpu_b),
    .cpu_alucont   (cpu_alucont),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_alucont   (alu_alucont),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .test_busy     (test_busy),
    .test_pass_cnt (test_pass_cnt),
    .fault_cnt     (fault_cnt),
    .alu_fault     (alu_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Voted ALU model with optional bit0 stuck-at-1 fault
  logic [31:0] alu_raw;
  always_comb begin
    alu_raw = '0;
    case (alu_alucont)
      3'b000: alu_raw = alu_a & alu_b;
      3'b001: alu_raw = alu_a | alu_b;
      3'b010: alu_raw = alu_a + alu_b;
      3'b110: alu_raw = alu_a - alu_b;
      3'b111: alu_raw = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_raw = '0;
    endcase
    alu_result = alu_raw | {31'd0, stuck};
    alu_zero   = (alu_result == 32'd0);
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  typedef struct {
    logic        req;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] ea, eb;
    logic [2:0]  eop;
  } mux_rec_t;

  exp_t     ref_vec [NUM_VEC];
  exp_t     vq[$];
  exp_t     mon_e;
  mux_rec_t mux_tab [4];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every vector seen on the ALU port must be the next one expected
  always @(negedge clk) begin
    if (cpu_req) begin
      chk("cpu_priority", 96'({alu_a, alu_b, alu_alucont}), 96'({cpu_a, cpu_b, cpu_alucont}));
    end else if ({alu_a, alu_b, alu_alucont} != {cpu_a, cpu_b, cpu_alucont}) begin
      if (vq.size() == 0) begin
        chk("unexpected_vector", 96'({alu_a, alu_b, alu_alucont}), 96'({cpu_a, cpu_b, cpu_alucont}));
      end else begin
        mon_e = vq.pop_front();
        chk("vector_order", 96'({alu_a, alu_b, alu_alucont}), 96'(mon_e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_quiet();
    cpu_req     = 1'b0;
    cpu_a       = 32'hDEADBEEF;
    cpu_b       = 32'hCAFE0001;
    cpu_alucont = 3'b011;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NUM_VEC; i++) vq.push_back(ref_vec[i]);
  endtask

  task automatic wait_busy(input logic lvl, output int n);
    n = 0;
    @(negedge clk);
    while (test_busy !== lvl && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("busy_timeout", 96'(test_busy), 96'(lvl));
  endtask

  task automatic sweep(output int idle_n, output int busy_n);
    push_sweep();
    wait_busy(1'b1, idle_n);
    wait_busy(1'b0, busy_n);
    busy_n++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int idle_n, busy_n;
    ref_vec[0] = '{a: 32'hF0F0F0F0, b: 32'h0FF00FF0, op: 3'b000};
    ref_vec[1] = '{a: 32'hF0F0F0F0, b: 32'h0FF00FF0, op: 3'b001};
    ref_vec[2] = '{a: 32'h7FFFFFFF, b: 32'h00000001, op: 3'b010};
    ref_vec[3] = '{a: 32'h00000005, b: 32'h00000005, op: 3'b110};
    ref_vec[4] = '{a: 32'h00000003, b: 32'h00000007, op: 3'b111};
    mux_tab[0] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 3'b010, 32'h12345678, 32'h9ABCDEF0, 3'b010};
    mux_tab[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 3'b111, 32'hFFFFFFFF, 32'h00000000, 3'b111};
    mux_tab[2] = '{1'b0, 32'h00000000, 32'hA5A5A5A5, 3'b110, 32'h00000000, 32'hA5A5A5A5, 3'b110};
    mux_tab[3] = '{1'b1, 32'h80000001, 32'h7FFFFFFE, 3'b001, 32'h80000001, 32'h7FFFFFFE, 3'b001};

    stuck   = 1'b0;
    reset   = 1'b1;
    test_en = 1'b0;
    cpu_quiet();
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 96'(test_busy), 96'(0));
    chk("rst_pass", 96'(test_pass_cnt), 96'(0));
    chk("rst_fault_cnt", 96'(fault_cnt), 96'(0));
    chk("rst_alu_fault", 96'(alu_fault), 96'(0));

    // CPU pass-through while idle
    for (int i = 0; i < 4; i++) begin
      tick(1);
      cpu_req = mux_tab[i].req; cpu_a = mux_tab[i].a;
      cpu_b = mux_tab[i].b; cpu_alucont = mux_tab[i].op;
      @(negedge clk);
      chk("idle_mux", 96'({alu_a, alu_b, alu_alucont}),
          96'({mux_tab[i].ea, mux_tab[i].eb, mux_tab[i].eop}));
    end
    tick(1);
    cpu_quiet();

    // Basic sweep: 4 WAIT cycles, 6 busy cycles, one pass
    test_en = 1'b1;
    sweep(idle_n, busy_n);
    chk("first_idle_cycles", 96'(idle_n), 96'(5));
    chk("first_busy_cycles", 96'(busy_n), 96'(6));
    chk("first_pass", 96'(test_pass_cnt), 96'(1));
    chk("first_fault_cnt", 96'(fault_cnt), 96'(0));
    chk("first_queue_empty", 96'(vq.size()), 96'(0));

    // CPU steals 3 cycles at idx=2; sweep must resume, not restart
    push_sweep();
    wait_busy(1'b1, idle_n);
    chk("wait_len", 96'(idle_n), 96'(3));
    tick(2);
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_a = $urandom; cpu_b = $urandom; cpu_alucont = 3'($urandom_range(7));
      @(negedge clk);
      chk("steal_busy", 96'(test_busy), 96'(1));
      tick(1);
    end
    cpu_quiet();
    wait_busy(1'b0, busy_n);
    chk("steal_pass", 96'(test_pass_cnt), 96'(2));
    chk("steal_fault_cnt", 96'(fault_cnt), 96'(0));
    chk("steal_queue_empty", 96'(vq.size()), 96'(0));

    // Drop test_en at idx=3: abort without any tally
    push_sweep();
    wait_busy(1'b1, idle_n);
    tick(3);
    test_en = 1'b0;
    tick(1);
    @(negedge clk);
    chk("abort_busy", 96'(test_busy), 96'(0));
    chk("abort_pass", 96'(test_pass_cnt), 96'(2));
    chk("abort_fault_cnt", 96'(fault_cnt), 96'(0));
    chk("abort_vecs_left", 96'(vq.size()), 96'(1));
    vq.delete();
    tick(1);
    test_en = 1'b1;
    sweep(idle_n, busy_n);
    chk("reen_idle_cycles", 96'(idle_n), 96'(5));
    chk("reen_pass", 96'(test_pass_cnt), 96'(3));

    // Stuck-at-1 on result bit0
    stuck = 1'b1;
    sweep(idle_n, busy_n);
    chk("stuck1_fault_cnt", 96'(fault_cnt), 96'(1));
    chk("stuck1_alu_fault", 96'(alu_fault), 96'(0));
    chk("stuck1_pass", 96'(test_pass_cnt), 96'(3));
    sweep(idle_n, busy_n);
    chk("stuck2_fault_cnt", 96'(fault_cnt), 96'(2));
    chk("stuck2_alu_fault", 96'(alu_fault), 96'(1));
    stuck = 1'b0;
    sweep(idle_n, busy_n);
    chk("healed_pass", 96'(test_pass_cnt), 96'(4));
    chk("healed_fault_cnt", 96'(fault_cnt), 96'(2));
    chk("healed_alu_fault_sticky", 96'(alu_fault), 96'(1));

    // Reset mid-RUN
    push_sweep();
    wait_busy(1'b1, idle_n);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("midrst_busy", 96'(test_busy), 96'(0));
    chk("midrst_pass", 96'(test_pass_cnt), 96'(0));
    chk("midrst_fault_cnt", 96'(fault_cnt), 96'(0));
    chk("midrst_alu_fault", 96'(alu_fault), 96'(0));
    chk("midrst_mux", 96'({alu_a, alu_b, alu_alucont}), 96'({cpu_a, cpu_b, cpu_alucont}));
    vq.delete();
    reset = 1'b0;

    // Pass counter saturation
    for (int k = 1; k <= 300; k++) begin
      sweep(idle_n, busy_n);
      chk("pass_sat", 96'(test_pass_cnt), 96'((k > 255) ? 255 : k));
    end
    chk("sat_fault_cnt", 96'(fault_cnt), 96'(0));
    chk("sat_alu_fault", 96'(alu_fault), 96'(0));

    test_en = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
